// File: rtl/fork_reduce_pkg.sv
// Shared types and helpers for the flag/vector fork-and-reduce pipeline.
package fork_reduce_pkg;

    typedef enum logic [1:0] {
        RED_OR  = 2'd0,
        RED_XOR = 2'd1,
        RED_AND = 2'd2
    } red_mode_e;

    localparam int RED_MAX_W = 64;

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Only the low 'width' bits of word take part in the reduction.
    function automatic logic reduce_word(
        input logic [RED_MAX_W-1:0] word,
        input int                   width,
        input red_mode_e            mode
    );
        logic r_or;
        logic r_xor;
        logic r_and;
        r_or  = 1'b0;
        r_xor = 1'b0;
        r_and = 1'b1;
        for (int i = 0; i < RED_MAX_W; i++) begin
            if (i < width) begin
                r_or  = r_or | word[i];
                r_xor = r_xor ^ word[i];
                r_and = r_and & word[i];
            end
        end
        case (mode)
            RED_XOR: return r_xor;
            RED_AND: return r_and;
            default: return r_or;
        endcase
    endfunction

endpackage

// File: rtl/fork_reduce_pipe_fifo.sv
// Synchronous FIFO with a registered head word and occupancy counter.
module sync_fifo #(
    parameter  int W     = 1,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] rd_nxt;
    logic [LW-1:0] level_q, level_d;
    logic [W-1:0]  head_q, head_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        rd_nxt   = rd_ptr_q + PW'(1);
        level_d  = level_q + LW'(push) - LW'(pop);
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_nxt;
        // Head reloads from the incoming word when it becomes the only entry,
        // otherwise from the next stored entry after a pop.
        if (push && (level_q == '0 || (pop && level_q == LW'(1))))
            head_d = wdata;
        else if (pop && level_q > LW'(1))
            head_d = mem_q[rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = head_q;
    assign level = level_q;

endmodule

// File: rtl/fork_reduce_pipe.sv
// Forks each accepted {flag, vec} word into an inverted-vector lane
// and a reduction-bit lane, each buffered by its own FIFO.
module fork_reduce_pipe
    import fork_reduce_pkg::*;
#(
    parameter int IN_W     = 2,
    parameter int DEPTH    = 4,
    parameter int RED_MODE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_flag,
    input  logic [IN_W-1:0]            in_vec,
    output logic                       a_valid,
    input  logic                       a_ready,
    output logic [IN_W-1:0]            a_vec,
    output logic                       b_valid,
    input  logic                       b_ready,
    output logic                       b_bit,
    output logic [$clog2(DEPTH+1)-1:0] a_level,
    output logic [$clog2(DEPTH+1)-1:0] b_level
);

    localparam int        LVL_W = lvl_w(DEPTH);
    localparam red_mode_e MODE  = red_mode_e'(RED_MODE);

    logic                 accept;
    logic                 a_pop;
    logic                 b_pop;
    logic [IN_W:0]        word;
    logic [RED_MAX_W-1:0] word_ext;
    logic [IN_W-1:0]      a_data;
    logic                 b_data;
    logic [LVL_W-1:0]     a_lvl;
    logic [LVL_W-1:0]     b_lvl;

    assign word     = {in_flag, in_vec};
    assign word_ext = RED_MAX_W'(word);
    assign a_data   = in_vec ^ {IN_W{in_flag}};
    assign b_data   = reduce_word(word_ext, IN_W + 1, MODE);

    // Levels are registered, so in_ready never depends on the lane readies.
    assign in_ready = rst_n && (a_lvl < LVL_W'(DEPTH))
                            && (b_lvl < LVL_W'(DEPTH));
    assign accept   = in_valid && in_ready;

    assign a_valid  = (a_lvl != '0);
    assign b_valid  = (b_lvl != '0);
    assign a_pop    = a_valid && a_ready;
    assign b_pop    = b_valid && b_ready;

    sync_fifo #(.W(IN_W), .DEPTH(DEPTH)) u_lane_a (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (a_pop),
        .wdata (a_data),
        .rdata (a_vec),
        .level (a_lvl)
    );

    sync_fifo #(.W(1), .DEPTH(DEPTH)) u_lane_b (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (b_pop),
        .wdata (b_data),
        .rdata (b_bit),
        .level (b_lvl)
    );

    assign a_level = a_lvl;
    assign b_level = b_lvl;

endmodule

// File: tb/tb_fork_reduce_pipe.sv
// Scoreboard bench for fork_reduce_pipe (IN_W=2, DEPTH=4, XOR reduction).
module tb_fork_reduce_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_flag;
    logic [1:0] in_vec;
    logic       a_valid;
    logic       a_ready;
    logic [1:0] a_vec;
    logic       b_valid;
    logic       b_ready;
    logic       b_bit;
    logic [2:0] a_level;
    logic [2:0] b_level;

    always #5 clk = ~clk;

    fork_reduce_pipe #(.IN_W(2), .DEPTH(4), .RED_MODE(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_flag  (in_flag),
        .in_vec   (in_vec),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_vec    (a_vec),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_bit    (b_bit),
        .a_level  (a_level),
        .b_level  (b_level)
    );

    logic [1:0] qa[$];
    logic       qb[$];
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: a pop happens at the next rising edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (a_valid && a_ready) begin
                if (qa.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL lane_a_unexpected: got %0h expected none",
                             a_vec);
                end else begin
                    chk("lane_a_data", 32'(a_vec), 32'(qa.pop_front()));
                end
            end
            if (b_valid && b_ready) begin
                if (qb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL lane_b_unexpected: got %0h expected none",
                             b_bit);
                end else begin
                    chk("lane_b_data", 32'(b_bit), 32'(qb.pop_front()));
                end
            end
        end
    end

    task automatic offer(input logic v, input logic f, input logic [1:0] vec,
                         input logic ar, input logic br, output logic acc);
        @(posedge clk);
        #1;
        in_valid = v;
        in_flag  = f;
        in_vec   = vec;
        a_ready  = ar;
        b_ready  = br;
        @(negedge clk);
        acc = v && in_ready;
        if (acc) begin
            qa.push_back(vec ^ {2{f}});
            qb.push_back(^{f, vec});
        end
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 40 && (qa.size() != 0 || qb.size() != 0); i++)
            offer(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, acc);
        chk("drain_a_empty", 32'(qa.size()), 0);
        chk("drain_b_empty", 32'(qb.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   cnt;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_flag  = 1'b0;
        in_vec   = 2'd0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;

        // 1. reset
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready_c1", 32'(in_ready), 0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready_c2", 32'(in_ready), 0);
        chk("rst_a_level", 32'(a_level), 0);
        chk("rst_b_level", 32'(b_level), 0);
        chk("rst_a_valid", 32'(a_valid), 0);
        chk("rst_b_valid", 32'(b_valid), 0);
        chk("rst_a_vec", 32'(a_vec), 0);
        chk("rst_b_bit", 32'(b_bit), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // 2. single word
        offer(1'b1, 1'b1, 2'b01, 1'b1, 1'b1, acc);
        chk("single_accept", 32'(acc), 1);
        offer(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, acc);
        chk("single_a_valid", 32'(a_valid), 1);
        chk("single_a_vec", 32'(a_vec), 32'h2);
        chk("single_b_valid", 32'(b_valid), 1);
        chk("single_b_bit", 32'(b_bit), 0);
        offer(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, acc);
        chk("single_a_gone", 32'(a_valid), 0);
        chk("single_b_gone", 32'(b_valid), 0);

        // 3. skewed backpressure
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 1'b0, 2'(i), 1'b0, 1'b1, acc);
            chk("skew_accept", 32'(acc), 1);
        end
        offer(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, acc);
        chk("skew_full_block", 32'(acc), 0);
        chk("skew_a_level", 32'(a_level), 4);
        offer(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, acc);
        chk("skew_full_hold", 32'(acc), 0);
        chk("skew_a_level2", 32'(a_level), 4);
        chk("skew_b_level", 32'(b_level), 0);

        // 4. release lane A
        offer(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, acc);
        chk("release_first_pop_cycle", 32'(acc), 0);
        offer(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, acc);
        chk("release_fifth_accept", 32'(acc), 1);
        drain();

        // 5. mid-operation reset
        for (int i = 1; i < 4; i++) begin
            offer(1'b1, 1'b1, 2'(i), 1'b0, 1'b0, acc);
            chk("midrst_fill", 32'(acc), 1);
        end
        offer(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, acc);
        chk("midrst_a_level", 32'(a_level), 3);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        qa.delete();
        qb.delete();
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_a_level0", 32'(a_level), 0);
        chk("midrst_b_level0", 32'(b_level), 0);
        chk("midrst_a_valid0", 32'(a_valid), 0);
        chk("midrst_b_valid0", 32'(b_valid), 0);
        for (int i = 0; i < 6; i++)
            offer(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, acc);
        chk("midrst_still_empty", 32'(a_valid | b_valid), 0);

        // 6. streaming
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            offer(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'b1, 1'b1, acc);
            if (acc) cnt++;
            if (i > 0) begin
                chk("stream_a_level", 32'(a_level), 1);
                chk("stream_b_level", 32'(b_level), 1);
            end
        end
        chk("stream_accepts", 32'(cnt), 64);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
